// File: rtl/rgb2hsv_pkg.sv
// Shared constants and width helpers for the RGB->HSV/HSL stage-2 pipeline.
package rgb2hsv_pkg;

   localparam logic [8:0] HUE_0   = 9'd0;
   localparam logic [8:0] HUE_120 = 9'd120;
   localparam logic [8:0] HUE_240 = 9'd240;
   localparam logic [8:0] HUE_360 = 9'd360;

   localparam int unsigned SCALE_V = 100;

   typedef enum logic {
      MODE_HSV = 1'b0,
      MODE_HSL = 1'b1
   } mode_e;

   // Signed hue numerator needs one extra bit over a channel.
   function automatic int unsigned hnum_w(input int unsigned w);
      return w + 1;
   endfunction

   // max*100 needs 7 extra bits since 100 < 2^7.
   function automatic int unsigned vscl_w(input int unsigned w);
      return w + 7;
   endfunction

endpackage

// File: rtl/rgb2hsv_lane_calc.sv
// Combinational per-lane arithmetic: delta, hue numerator/offset, value term, sat denominator.
module rgb2hsv_lane_calc
   import rgb2hsv_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] r,
   input  logic [W-1:0] g,
   input  logic [W-1:0] b,
   input  logic [W-1:0] in_max,
   input  logic [W-1:0] in_min,
   input  logic         mode,
   output logic [W-1:0] delta,
   output logic [W:0]   h_num,
   output logic [8:0]   h_add,
   output logic [W+6:0] v_scaled,
   output logic [W:0]   s_den,
   output logic         achrom,
   output logic         err
);

   localparam logic [W:0]   FS_EXT    = {1'b0, {W{1'b1}}};
   localparam logic [W:0]   TWO_FS    = {{W{1'b1}}, 1'b0};
   localparam logic [W+6:0] SCALE_EXT = (W+7)'(SCALE_V);

   logic         hue_err;
   logic [W:0]   l_sum;

   always_comb begin
      delta    = in_max - in_min;
      achrom   = (delta == '0);
      h_num    = '0;
      h_add    = HUE_0;
      hue_err  = 1'b0;
      // Ties resolve r first, then g, then b.
      if (in_max == r) begin
         h_num = {1'b0, g} - {1'b0, b};
         h_add = (g < b) ? HUE_360 : HUE_0;
      end else if (in_max == g) begin
         h_num = {1'b0, b} - {1'b0, r};
         h_add = HUE_120;
      end else if (in_max == b) begin
         h_num = {1'b0, r} - {1'b0, g};
         h_add = HUE_240;
      end else begin
         hue_err = 1'b1;
      end
      err      = hue_err | (in_min > in_max);
      v_scaled = {7'b0, in_max} * SCALE_EXT;
      l_sum    = {1'b0, in_max} + {1'b0, in_min};
      if (mode == MODE_HSL)
         s_den = (l_sum <= FS_EXT) ? l_sum : (TWO_FS - l_sum);
      else
         s_den = {1'b0, in_max};
   end

endmodule

// File: rtl/rgb2hsv_stage2_px.sv
// Stage 2 of the RGB->HSV/HSL pipeline: LANES parallel lane calcs feeding a LAT-deep elastic register pipe.
module rgb2hsv_stage2_px
   import rgb2hsv_pkg::*;
#(
   parameter int unsigned W     = 8,
   parameter int unsigned LANES = 2,
   parameter int unsigned LAT   = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          mode,
   input  logic [LANES*W-1:0]            r,
   input  logic [LANES*W-1:0]            g,
   input  logic [LANES*W-1:0]            b,
   input  logic [LANES*W-1:0]            in_max,
   input  logic [LANES*W-1:0]            in_min,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES*W-1:0]            delta,
   output logic [LANES*hnum_w(W)-1:0]    h_num,
   output logic [LANES*9-1:0]            h_add,
   output logic [LANES*vscl_w(W)-1:0]    v_scaled,
   output logic [LANES*hnum_w(W)-1:0]    s_den,
   output logic [LANES*W-1:0]            out_max,
   output logic [LANES-1:0]              achrom,
   output logic [LANES-1:0]              err
);

   localparam int unsigned HW = hnum_w(W);
   localparam int unsigned VW = vscl_w(W);

   logic                   adv;
   logic [LANES*W-1:0]     c_delta;
   logic [LANES*HW-1:0]    c_h_num;
   logic [LANES*9-1:0]     c_h_add;
   logic [LANES*VW-1:0]    c_v_scaled;
   logic [LANES*HW-1:0]    c_s_den;
   logic [LANES-1:0]       c_achrom;
   logic [LANES-1:0]       c_err;

   logic                   vld_q      [LAT];
   logic [LANES*W-1:0]     delta_q    [LAT];
   logic [LANES*HW-1:0]    h_num_q    [LAT];
   logic [LANES*9-1:0]     h_add_q    [LAT];
   logic [LANES*VW-1:0]    v_scaled_q [LAT];
   logic [LANES*HW-1:0]    s_den_q    [LAT];
   logic [LANES*W-1:0]     max_q      [LAT];
   logic [LANES-1:0]       achrom_q   [LAT];
   logic [LANES-1:0]       err_q      [LAT];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      rgb2hsv_lane_calc #(.W(W)) u_calc (
         .r        (r[l*W +: W]),
         .g        (g[l*W +: W]),
         .b        (b[l*W +: W]),
         .in_max   (in_max[l*W +: W]),
         .in_min   (in_min[l*W +: W]),
         .mode     (mode),
         .delta    (c_delta[l*W +: W]),
         .h_num    (c_h_num[l*HW +: HW]),
         .h_add    (c_h_add[l*9 +: 9]),
         .v_scaled (c_v_scaled[l*VW +: VW]),
         .s_den    (c_s_den[l*HW +: HW]),
         .achrom   (c_achrom[l]),
         .err      (c_err[l])
      );
   end

   // Whole pipe advances together, gated only by the output slot.
   assign adv      = ~vld_q[LAT-1] | out_ready;
   assign in_ready = adv;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < LAT; i++) begin
            vld_q[i]      <= 1'b0;
            delta_q[i]    <= '0;
            h_num_q[i]    <= '0;
            h_add_q[i]    <= '0;
            v_scaled_q[i] <= '0;
            s_den_q[i]    <= '0;
            max_q[i]      <= '0;
            achrom_q[i]   <= '0;
            err_q[i]      <= '0;
         end
      end else if (adv) begin
         vld_q[0]      <= in_valid;
         delta_q[0]    <= c_delta;
         h_num_q[0]    <= c_h_num;
         h_add_q[0]    <= c_h_add;
         v_scaled_q[0] <= c_v_scaled;
         s_den_q[0]    <= c_s_den;
         max_q[0]      <= in_max;
         achrom_q[0]   <= c_achrom;
         err_q[0]      <= c_err;
         for (int unsigned i = 1; i < LAT; i++) begin
            vld_q[i]      <= vld_q[i-1];
            delta_q[i]    <= delta_q[i-1];
            h_num_q[i]    <= h_num_q[i-1];
            h_add_q[i]    <= h_add_q[i-1];
            v_scaled_q[i] <= v_scaled_q[i-1];
            s_den_q[i]    <= s_den_q[i-1];
            max_q[i]      <= max_q[i-1];
            achrom_q[i]   <= achrom_q[i-1];
            err_q[i]      <= err_q[i-1];
         end
      end
   end

   assign out_valid = vld_q[LAT-1];
   assign delta     = delta_q[LAT-1];
   assign h_num     = h_num_q[LAT-1];
   assign h_add     = h_add_q[LAT-1];
   assign v_scaled  = v_scaled_q[LAT-1];
   assign s_den     = s_den_q[LAT-1];
   assign out_max   = max_q[LAT-1];
   assign achrom    = achrom_q[LAT-1];
   assign err       = err_q[LAT-1];

endmodule
